// File: rtl/fetch_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_control_unit
// Description : Fetch sequencer for the 5-stage MIPS pipeline. Watches the
//               ID-stage instruction, EX-stage load/branch status and the
//               data-memory busy flag, and drives the program memory block's
//               stall, stall_pm, pc_mux_sel and jmp_loc inputs plus the
//               ID/EX squash strobes.
//               Optional feature macro: FETCH_PERF_CNT_EN adds saturating
//               stall_cycles / redirect_cnt performance counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_control_unit #(
  parameter int ADDR_W   = 16,
  parameter int INS_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins_id,
  input  logic              ex_load,
  input  logic [4:0]        ex_rd,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              mem_busy,
  output logic              stall,
  output logic              stall_pm,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              mem_timeout,
  output logic [2:0]        fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       redirect_cnt
`endif
);

  // State encoding is visible on fsm_state, so the values are fixed.
  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_LU_STALL = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_FLUSH    = 3'd4
  } state_t;

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_j     = 6'b000010;

  // Registered state and outputs
  state_t            r_state;
  logic [7:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_target;
  logic              r_br_flag;
  logic              r_stall;
  logic              r_pc_mux_sel;
  logic              r_flush_id;
  logic              r_flush_ex;
  logic              r_mem_timeout;

  // Decode of the ID-stage instruction
  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic              w_rt_used;
  logic              w_is_jump;
  logic              w_lu;
  logic [ADDR_W-1:0] w_jump_tgt;

  // Next-state / next-output values
  state_t            w_state_nxt;
  logic [7:0]        w_cnt_nxt;
  logic              w_timeout_set;
  logic [ADDR_W-1:0] w_target_nxt;
  logic              w_br_flag_nxt;
  logic              w_stall_nxt;
  logic              w_pc_mux_sel_nxt;
  logic              w_flush_id_nxt;
  logic              w_flush_ex_nxt;

  assign w_op       = ins_id[31:26];
  assign w_rs       = ins_id[25:21];
  assign w_rt       = ins_id[20:16];
  assign w_rt_used  = (w_op == c_op_rtype) || (w_op == c_op_beq) ||
                      (w_op == c_op_bne)   || (w_op == c_op_sw);
  assign w_is_jump  = (w_op == c_op_j);
  assign w_jump_tgt = ADDR_W'(ins_id[15:0]);

  // A load whose destination is read by the ID instruction needs one bubble.
  // Register 0 is hard-wired, so a load to r0 never creates a hazard.
  assign w_lu = ex_load && (ex_rd != 5'd0) &&
                ((ex_rd == w_rs) || (w_rt_used && (ex_rd == w_rt)));

  // Next-state selection and decode of the outputs for the next state
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = '0;
    w_timeout_set    = 1'b0;
    w_target_nxt     = r_target;
    w_br_flag_nxt    = r_br_flag;
    w_stall_nxt      = 1'b0;
    w_pc_mux_sel_nxt = 1'b0;
    w_flush_id_nxt   = 1'b0;
    w_flush_ex_nxt   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (mem_busy) begin
          w_state_nxt = ST_MEM_WAIT;
        end else if (br_taken) begin
          w_state_nxt   = ST_REDIRECT;
          w_target_nxt  = br_target;
          w_br_flag_nxt = 1'b1;
        end else if (w_is_jump) begin
          w_state_nxt   = ST_REDIRECT;
          w_target_nxt  = w_jump_tgt;
          w_br_flag_nxt = 1'b0;
        end else if (w_lu) begin
          w_state_nxt = ST_LU_STALL;
        end
      end

      ST_LU_STALL: begin
        w_state_nxt = mem_busy ? ST_MEM_WAIT : ST_RUN;
      end

      // EX is frozen here, so branch/jump/load-use are re-presented later.
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          w_state_nxt = ST_RUN;
        end else if ((r_wait_cnt + 8'd1) == c_max_wait) begin
          w_state_nxt   = ST_RUN;
          w_timeout_set = 1'b1;
        end else begin
          w_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end

      // The redirect always completes; a busy memory is handled in FLUSH.
      ST_REDIRECT: begin
        w_state_nxt = ST_FLUSH;
      end

      // Branch/jump seen here belong to the wrong path and are dropped.
      ST_FLUSH: begin
        w_state_nxt = mem_busy ? ST_MEM_WAIT : ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    case (w_state_nxt)
      ST_LU_STALL: begin
        w_stall_nxt    = 1'b1;
        w_flush_ex_nxt = 1'b1;
      end
      ST_MEM_WAIT: begin
        w_stall_nxt = 1'b1;
      end
      ST_REDIRECT: begin
        w_pc_mux_sel_nxt = 1'b1;
        w_flush_id_nxt   = 1'b1;
        w_flush_ex_nxt   = w_br_flag_nxt;
      end
      ST_FLUSH: begin
        w_flush_id_nxt = 1'b1;
      end
      default: begin
        w_stall_nxt = 1'b0;
      end
    endcase
  end

  // State, wait counter, redirect target and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_target      <= '0;
      r_br_flag     <= 1'b0;
      r_stall       <= 1'b0;
      r_pc_mux_sel  <= 1'b0;
      r_flush_id    <= 1'b0;
      r_flush_ex    <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_cnt_nxt;
      r_target     <= w_target_nxt;
      r_br_flag    <= w_br_flag_nxt;
      r_stall      <= w_stall_nxt;
      r_pc_mux_sel <= w_pc_mux_sel_nxt;
      r_flush_id   <= w_flush_id_nxt;
      r_flush_ex   <= w_flush_ex_nxt;
      if (w_timeout_set) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // jmp_loc is the latched target; it only changes on entry to REDIRECT.
  assign stall       = r_stall;
  assign stall_pm    = r_stall;
  assign pc_mux_sel  = r_pc_mux_sel;
  assign jmp_loc     = r_target;
  assign flush_id    = r_flush_id;
  assign flush_ex    = r_flush_ex;
  assign mem_timeout = r_mem_timeout;
  assign fsm_state   = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_redirect_cnt;

  // Saturating counts of stalled cycles and redirect entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (r_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if ((w_state_nxt == ST_REDIRECT) && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
`default_nettype wire
